// File: rtl/cla_wide_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cla_wide_seq : WORDS x 16-bit add/sub sequenced through one cla_top  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+

// Registered 16-bit carry-lookahead adder (4-bit groups, lookahead across groups).
module cla_top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        carry_out16
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_gc;

  always_comb begin
    w_g  = a & b;
    w_p  = a ^ b;
    w_gg = '0;
    w_gp = '0;
    w_gc = '0;
    w_c  = '0;
    for (int j = 0; j < 4; j++) begin
      w_gg[j] = w_g[4*j+3]
              | (w_p[4*j+3] & w_g[4*j+2])
              | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
              | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
      w_gp[j] = &w_p[4*j +: 4];
    end
    // Group carries are flattened so no carry ripples between groups.
    w_gc[0] = cin;
    w_gc[1] = w_gg[0] | (w_gp[0] & cin);
    w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin);
    w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
            | (w_gp[2] & w_gp[1] & w_gp[0] & cin);
    w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
            | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
            | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & cin);
    for (int j = 0; j < 4; j++) begin
      w_c[4*j] = w_gc[j];
      for (int k = 0; k < 3; k++) begin
        w_c[4*j+k+1] = w_g[4*j+k] | (w_p[4*j+k] & w_c[4*j+k]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum         <= '0;
      carry_out16 <= 1'b0;
    end else begin
      sum         <= w_p ^ w_c;
      carry_out16 <= w_gc[4];
    end
  end

endmodule

module cla_wide_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] in_a,
  input  logic [16*WORDS-1:0] in_b,
  input  logic                in_cin,
  input  logic                in_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] out_sum,
  output logic                out_cout,
  output logic                out_ovf
);

  localparam int W  = 16 * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [KW-1:0]  r_k;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_c0;

  logic [15:0]    w_cla_a;
  logic [15:0]    w_cla_b;
  logic           w_cla_cin;
  logic [15:0]    w_cla_sum;
  logic           w_cla_cout;

  assign in_ready  = (r_state == S_IDLE) && rst_n;
  assign out_valid = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = S_RUN;
      S_RUN:  if (r_k == KW'(WORDS - 1)) w_next = S_LAST;
      S_LAST: w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Slice mux feeding the shared adder.
  always_comb begin
    w_cla_a = '0;
    w_cla_b = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (r_k == KW'(i)) begin
        w_cla_a = r_a[16*i +: 16];
        w_cla_b = r_b[16*i +: 16];
      end
    end
    // Slice 0 never sees the adder's leftover carry from a previous request.
    w_cla_cin = (r_state == S_RUN && r_k == '0) ? r_c0 : w_cla_cout;
  end

  cla_top u_cla (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (w_cla_a),
    .b           (w_cla_b),
    .cin         (w_cla_cin),
    .sum         (w_cla_sum),
    .carry_out16 (w_cla_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c0     <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_k  <= '0;
            r_a  <= in_a;
            r_b  <= in_sub ? ~in_b : in_b;
            r_c0 <= in_sub ? ~in_cin : in_cin;
          end
        end
        S_RUN: begin
          r_k <= r_k + 1'b1;
          for (int i = 1; i < WORDS; i++) begin
            if (r_k == KW'(i)) out_sum[16*(i-1) +: 16] <= w_cla_sum;
          end
        end
        S_LAST: begin
          out_sum[W-16 +: 16] <= w_cla_sum;
          out_cout            <= w_cla_cout;
          out_ovf             <= (r_a[W-1] == r_b[W-1]) && (w_cla_sum[15] != r_a[W-1]);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cla_wide_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cla_wide_seq : scoreboard bench for cla_wide_seq (WORDS=4)        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cla_wide_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  cla_wide_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result: got sum %h with no request outstanding", out_sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_sum",  out_sum,          e.sum);
        check("out_cout", W'(out_cout),     W'(e.cout));
        check("out_ovf",  W'(out_ovf),      W'(e.ovf));
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input logic push, input exp_t e);
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 50);
    if (!in_ready) begin
      n_total++;
      $display("FAIL in_ready_timeout: got 0 required 1");
    end
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(posedge clk);
    if (push) q.push_back(e);
    #1;
    in_valid = 1'b0;
    in_a = '1; in_b = '1; in_cin = 1'b1; in_sub = ~sub;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic [W-1:0] s,
                        input logic co, input logic ov);
    int cyc;
    exp_t e;
    e.sum = s; e.cout = co; e.ovf = ov;
    issue(a, b, cin, sub, 1'b1, e);
    wait_valid(cyc);
    check({name, "_latency"}, W'(cyc), W'(WORDS + 1));
    @(posedge clk);
    #1;
    check({name, "_valid_drop"}, W'(out_valid), '0);
  endtask

  initial begin
    int cyc;
    int seen;
    logic [W-1:0] hold_sum;
    logic         hold_cout;
    logic         hold_ovf;
    exp_t         e;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_out_sum",   out_sum,       '0);
    check("rst_in_ready",  W'(in_ready),  '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", W'(in_ready), W'(1));

    run_op("carry_chain",  64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0000_0000_0001_0000, 1'b0, 1'b0);
    run_op("full_ripple",  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
           64'h0, 1'b1, 1'b0);
    run_op("signed_ovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("sub_borrow_x", 64'h0000_0000_0001_0000, 64'h1, 1'b0, 1'b1,
           64'h0000_0000_0000_FFFF, 1'b1, 1'b0);
    run_op("sub_wrap",     64'h0, 64'h1, 1'b0, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op("sub_bin",      64'h5, 64'h2, 1'b1, 1'b1,
           64'h2, 1'b1, 1'b0);

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    e.sum = 64'h2345_6789_ABCD_F001; e.cout = 1'b0; e.ovf = 1'b0;
    issue(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 1'b1, e);
    wait_valid(cyc);
    check("bp_latency", W'(cyc), W'(WORDS + 1));
    hold_sum = out_sum; hold_cout = out_cout; hold_ovf = out_ovf;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid",    W'(out_valid), W'(1));
      check("bp_in_ready", W'(in_ready),  '0);
      check("bp_sum_hold", out_sum,       hold_sum);
      check("bp_cout_ovf", W'({out_cout, out_ovf}), W'({hold_cout, hold_ovf}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_drop", W'(out_valid), '0);

    // Mid-operation reset during RUN(2): no result may appear.
    e = '0;
    issue(64'h3, 64'h4, 1'b0, 1'b0, 1'b0, e);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready",  W'(in_ready),  '0);
    check("midrst_out_valid", W'(out_valid), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_valid", W'(seen), '0);

    run_op("after_rst", 64'd10, 64'd12, 1'b0, 1'b0, 64'd22, 1'b0, 1'b0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout required finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
